// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/bubble control for load-use, branch redirect and multi-cycle freezes.
// Optional HAZARD_PERF_CNT_EN adds a saturating stall_cycles counter output.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] de_rs1,
  input  logic [4:0] de_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_muldiv_start,
  input  logic       ex_branch_taken,
  output logic       stall_pc,
  output logic       stall_fd,
  output logic       stall_de,
  output logic       bubble_fd,
  output logic       bubble_de,
  output logic       bubble_em
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy, freeze, br, lu;
  assign busy   = state_q == BUSY;
  assign freeze = busy || ex_muldiv_start;
  assign br     = !freeze && ex_branch_taken;
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu     = !freeze && !ex_branch_taken && ex_is_load && ex_rd != 5'd0 &&
                  (ex_rd == de_rs1 || ex_rd == de_rs2);
  assign stall_pc  = freeze || lu;
  assign stall_fd  = freeze || lu;
  assign stall_de  = freeze;
  assign bubble_fd = br;
  assign bubble_de = br || lu;
  assign bubble_em = freeze;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!busy) begin
      state_d = ex_muldiv_start ? BUSY : IDLE;
      cnt_d   = ex_muldiv_start ? 4'(MULDIV_CYCLES - 2) : cnt_q;
    end else begin
      state_d = cnt_q == 4'd0 ? IDLE : BUSY;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= 16'd0;
    else if (stall_pc && stall_cycles_q != 16'hFFFF) stall_cycles_q <= stall_cycles_q + 16'd1;
  end
  assign stall_cycles = stall_cycles_q;
`endif
endmodule
